// File: rtl/cmp_rr_scheduler_pkg.sv
// rtl/cmp_rr_scheduler_pkg.sv - shared FSM state type and constants for the compare scheduler
package cmp_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } sched_state_e;

    localparam int STATS_W = 32;

endpackage

// File: rtl/cmp_rr_scheduler_if.sv
// rtl/cmp_rr_scheduler_if.sv - requester and response handshake bundle for the compare scheduler
interface cmp_rr_scheduler_if #(
    parameter int N    = 8,
    parameter int NREQ = 4
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*N-1:0] req_a;
    logic [NREQ*N-1:0] req_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [N-1:0]      rsp_result;

    // Requester/consumer side
    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_result
    );

    // Scheduler side
    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_result
    );

endinterface

// File: rtl/cmp_rr_scheduler_cmp.sv
// rtl/cmp_rr_scheduler_cmp.sv - shared two's-complement signed less-than comparator
module signed_lt_cmp #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         lt
);

    // Single signed compare shared by every requester
    always_comb begin
        lt = ($signed(a) < $signed(b));
    end

endmodule

// File: rtl/cmp_rr_scheduler_rr_arbiter.sv
// rtl/cmp_rr_scheduler_rr_arbiter.sv - combinational round-robin pick starting at rr_ptr
module rr_arbiter
    import cmp_sched_pkg::*;
#(
    parameter int NREQ = 4,
    localparam int IDW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  rr_ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx,
    output logic            grant_valid
);

    int idx;

    // Walk rr_ptr, rr_ptr+1, ... with wrap and take the first active request
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        idx         = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(rr_ptr) + k) % NREQ;
            if (!grant_valid && req[idx]) begin
                grant_valid = 1'b1;
                grant[idx]  = 1'b1;
                grant_idx   = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/cmp_rr_scheduler.sv
// rtl/cmp_rr_scheduler.sv - round-robin scheduler sharing one signed compare; optional CMP_SCHED_STATS_EN adds op_count
module cmp_rr_scheduler
    import cmp_sched_pkg::*;
#(
    parameter int N    = 8,
    parameter int NREQ = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    cmp_rr_scheduler_if.slave bus,
`ifdef CMP_SCHED_STATS_EN
    output logic [STATS_W-1:0] op_count,
`endif
    output logic             busy
);

    localparam int IDW = $clog2(NREQ);
    localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);

    sched_state_e    state_q;
    sched_state_e    state_d;
    logic [IDW-1:0]  rr_ptr;
    logic [N-1:0]    a_q;
    logic [N-1:0]    b_q;
    logic [IDW-1:0]  id_q;
    logic            rsp_valid_q;
    logic [IDW-1:0]  rsp_id_q;
    logic [N-1:0]    rsp_result_q;
    logic [NREQ-1:0] req_ready_c;

    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_idx;
    logic            grant_valid;
    logic            lt;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .req         (bus.req_valid),
        .rr_ptr      (rr_ptr),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    signed_lt_cmp #(
        .N (N)
    ) u_cmp (
        .a  (a_q),
        .b  (b_q),
        .lt (lt)
    );

    assign bus.req_ready  = req_ready_c;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_result = rsp_result_q;
    assign busy           = (state_q != IDLE);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and the combinational accept strobe (only offered in IDLE)
    always_comb begin
        state_d     = state_q;
        req_ready_c = '0;
        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    req_ready_c = grant;
                    state_d     = EXEC;
                end
            end
            EXEC: begin
                state_d = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Operand latch, registered response and round-robin pointer update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr       <= '0;
            a_q          <= '0;
            b_q          <= '0;
            id_q         <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_valid) begin
                        a_q  <= bus.req_a[grant_idx*N +: N];
                        b_q  <= bus.req_b[grant_idx*N +: N];
                        id_q <= grant_idx;
                    end
                end
                EXEC: begin
                    rsp_valid_q  <= 1'b1;
                    rsp_id_q     <= id_q;
                    rsp_result_q <= {{(N-1){1'b0}}, lt};
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        // Next search starts just after the requester just served
                        if (rsp_id_q == LAST_ID) begin
                            rr_ptr <= '0;
                        end else begin
                            rr_ptr <= rsp_id_q + 1'b1;
                        end
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef CMP_SCHED_STATS_EN
    logic [STATS_W-1:0] op_count_q;

    assign op_count = op_count_q;

    // Saturating count of completed response handshakes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count_q <= '0;
        end else if (rsp_valid_q && bus.rsp_ready && (op_count_q != {STATS_W{1'b1}})) begin
            op_count_q <= op_count_q + 1'b1;
        end
    end
`endif

endmodule

// File: doc/cmp_rr_scheduler.md
Name: cmp_rr_scheduler

Overview:
Round-robin scheduler that shares one signed less-than comparator among NREQ requesters in the execution unit.
- Each requester presents an operand pair with a valid/ready handshake.
- The scheduler grants one requester, runs the compare, and returns a tagged result on a single response channel with valid/ready backpressure.
- Sits between the APB-side register/issue logic and the comparator datapath.

Parameters:
N, 8, operand and result width in bits (signed operands)
NREQ, 4, number of requesters; legal range 2..16
IDW, $clog2(NREQ), requester-ID width (derived; do not override)

Ports:
clk  in  1  clock; all state changes on rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NREQ  per-requester operand-pair valid
req_ready  out  NREQ  per-requester accept strobe (one-hot or zero)
req_a  in  NREQ*N  packed operand A; requester i uses bits [i*N +: N]
req_b  in  NREQ*N  packed operand B; same packing as req_a
rsp_valid  out  1  result valid
rsp_ready  in  1  consumer accepts result
rsp_id  out  IDW  index of the requester that owns the result
rsp_result  out  N  comparison result: 1 if signed A < B, else 0 (zero-extended to N)
busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE, rr_ptr = 0.
  - rsp_valid = 0, rsp_id = 0, rsp_result = 0, busy = 0, req_ready = 0.
  - Latched operands = 0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant = first i with req_valid[i] set, searching rr_ptr, rr_ptr+1, ... with wrap from NREQ-1 to 0.
  - req_ready[grant] = 1 combinationally in the same cycle. req_ready may depend on req_valid; req_valid must not depend on req_ready.
  - On that edge, latch A, B and grant index, then go to EXEC.
  - If no req_valid is set, stay in IDLE with req_ready = 0.
- EXEC (one cycle):
  - The comparator evaluates the latched operands.
  - rsp_result and rsp_id are registered; go to RESP with rsp_valid = 1.
- RESP:
  - rsp_valid, rsp_id and rsp_result hold stable until rsp_ready = 1.
  - On the handshake edge: rsp_valid goes to 0, rr_ptr = (rsp_id + 1) mod NREQ, go to IDLE.
- Latency and throughput:
  - Accept to rsp_valid is 2 cycles.
  - Best-case throughput is one operation per 3 cycles with rsp_ready held high.
- req_ready is 0 in EXEC and RESP. Requesters must hold req_valid and operands stable until accepted.
- Arithmetic: two's-complement signed compare on N bits. Result bit 0 = (A < B); bits [N-1:1] = 0.
- Boundary conditions:
  - Equal operands give 0.
  - Most-negative < most-positive gives 1.
  - Most-positive vs most-negative gives 0.
  - rr_ptr wraps from NREQ-1 to 0.
  - A requester deasserting req_valid before grant is legal and is skipped.
  - A requester re-requesting while its own result is pending is simply not granted until IDLE.
- Reset mid-operation: the in-flight operation is dropped, no response is produced, and rr_ptr returns to 0.
- Fairness: every continuously-valid requester is granted within NREQ operations.

Optional Feature:
CMP_SCHED_STATS_EN
- Defined:
  - Adds output port op_count (32 bits), reset to 0.
  - Increments on each response handshake (rsp_valid & rsp_ready) and saturates at 32'hFFFF_FFFF.
- Not defined:
  - Port and counter are absent.
  - All other behaviour is identical.

Decomposition:
- Shared package cmp_sched_pkg holds:
  - typedef enum logic [1:0] sched_state_e {IDLE, EXEC, RESP}.
  - localparam STATS_W = 32.
- Sub-module rr_arbiter (parameter NREQ).
  - Inputs: req vector and rr_ptr.
  - Outputs: one-hot grant and grant index.
  - Purely combinational.
- The top holds the FSM, operand latches, response registers and pointer.
- The comparator is the existing signed compare block, instantiated once with N.

Test Plan:
1. Reset check: assert rst_n = 0 mid-EXEC (A = 3, B = 5 from req 2) -> all outputs zero immediately, no rsp_valid afterwards, next grant searches from req 0.
2. Single request: req 1 only, A = -128, B = 127, N = 8 -> req_ready[1] for 1 cycle, rsp_valid 2 cycles later with rsp_id = 1, rsp_result = 8'h01.
3. Boundary compares: A = 127, B = -128 -> 0; A = 5, B = 5 -> 0; A = -1, B = 0 -> 1.
4. Round-robin fairness: all 4 req_valid held high, rsp_ready = 1 -> grant order 0, 1, 2, 3, 0, 1; each requester served once per 4 operations.
5. Backpressure: rsp_ready = 0 for 10 cycles in RESP -> rsp_valid, rsp_id and rsp_result stable, busy = 1, req_ready all 0; release -> IDLE the next cycle.
6. CMP_SCHED_STATS_EN defined: 6 completed operations -> op_count = 6; preload near saturation by force -> holds at 32'hFFFF_FFFF.
